// File: rtl/sprite_pkg.sv
// Shared types and default constants for the sprite blitter and its sub-blocks.
package sprite_pkg;

    localparam int COORD_W = 12;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam logic [11:0] DEF_TRANSPARENT_KEY = 12'h000;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } blit_state_t;

    typedef struct packed {
        coord_t src_x;
        coord_t src_y;
        coord_t dst_x;
        coord_t dst_y;
        coord_t width;
        coord_t height;
        logic   mirror;
    } blit_cmd_t;

endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register carrying a valid bit and a payload, aligned to ROM read latency.
module blit_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite rectangle from the sheet ROM to the frame-buffer write port,
// with mirroring, colour-key transparency and screen-edge clipping.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int COOR_WIDTH     = COORD_W,
    parameter int ROM_ADDR_WIDTH = 19,
    parameter int SHEET_WIDTH    = 404,
    parameter int PIXEL_WIDTH    = 12,
    parameter int ROM_LATENCY    = 2,
    parameter int SCREEN_W       = DEF_SCREEN_W,
    parameter int SCREEN_H       = DEF_SCREEN_H,
    parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT_KEY = PIXEL_WIDTH'(DEF_TRANSPARENT_KEY)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [COOR_WIDTH-1:0]     src_x,
    input  logic [COOR_WIDTH-1:0]     src_y,
    input  logic [COOR_WIDTH-1:0]     dst_x,
    input  logic [COOR_WIDTH-1:0]     dst_y,
    input  logic [COOR_WIDTH-1:0]     width,
    input  logic [COOR_WIDTH-1:0]     height,
    input  logic                      mirror_x,
    output logic                      busy,
    output logic                      done,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [PIXEL_WIDTH-1:0]    rom_data,
    output logic                      wr_en,
    output logic [COOR_WIDTH-1:0]     wr_x,
    output logic [COOR_WIDTH-1:0]     wr_y,
    output logic [PIXEL_WIDTH-1:0]    wr_data
);

    localparam int DW = $clog2(ROM_LATENCY + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LATENCY - 1);

    blit_state_t state_q, state_d;
    blit_cmd_t   cmd_q, cmd_d;
    logic [COOR_WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [DW-1:0] drain_q, drain_d;
    logic done_q, done_d;

    logic [COOR_WIDTH-1:0] w_m1, h_m1, sx;
    logic zero_cmd, row_end, last_read;

    assign w_m1      = COOR_WIDTH'(cmd_q.width) - COOR_WIDTH'(1);
    assign h_m1      = COOR_WIDTH'(cmd_q.height) - COOR_WIDTH'(1);
    assign zero_cmd  = (width == '0) || (height == '0);
    assign row_end   = (cx_q == w_m1);
    assign last_read = row_end && (cy_q == h_m1);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !zero_cmd) state_d = SCAN;
            SCAN:    if (last_read) state_d = DRAIN;
            DRAIN:   if (drain_q == DRAIN_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        rom_en = 1'b0;
        case (state_q)
            SCAN: begin
                busy   = 1'b1;
                rom_en = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    // Command latch, raster counters and drain timer.
    always_comb begin
        cmd_d   = cmd_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d.src_x  = coord_t'(src_x);
                    cmd_d.src_y  = coord_t'(src_y);
                    cmd_d.dst_x  = coord_t'(dst_x);
                    cmd_d.dst_y  = coord_t'(dst_y);
                    cmd_d.width  = coord_t'(width);
                    cmd_d.height = coord_t'(height);
                    cmd_d.mirror = mirror_x;
                    cx_d    = '0;
                    cy_d    = '0;
                    drain_d = '0;
                    done_d  = zero_cmd;
                end
            end
            SCAN: begin
                if (last_read) begin
                    cx_d = '0;
                    cy_d = '0;
                end else if (row_end) begin
                    cx_d = '0;
                    cy_d = cy_q + COOR_WIDTH'(1);
                end else begin
                    cx_d = cx_q + COOR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cmd_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    logic [ROM_ADDR_WIDTH-1:0] addr_col, addr_row;

    assign sx       = cmd_q.mirror ? (w_m1 - cx_q) : cx_q;
    assign addr_col = ROM_ADDR_WIDTH'(cmd_q.src_x) + ROM_ADDR_WIDTH'(sx);
    assign addr_row = ROM_ADDR_WIDTH'(cmd_q.src_y) + ROM_ADDR_WIDTH'(cy_q);
    assign rom_addr = rom_en ? (addr_col + ROM_ADDR_WIDTH'(SHEET_WIDTH) * addr_row) : '0;

    logic                      dl_valid;
    logic [2*COOR_WIDTH-1:0]   dl_data;
    logic [COOR_WIDTH:0]       wx_full, wy_full;

    blit_delay_line #(
        .DEPTH (ROM_LATENCY),
        .WIDTH (2 * COOR_WIDTH)
    ) u_delay (
        .clk       (clk),
        .clear     (rst_n),
        .in_valid  (rom_en),
        .in_data   ({cy_q, cx_q}),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

    // The extra carry bit catches destinations that wrap past the coordinate range.
    assign wx_full = {1'b0, COOR_WIDTH'(cmd_q.dst_x)} + {1'b0, dl_data[COOR_WIDTH-1:0]};
    assign wy_full = {1'b0, COOR_WIDTH'(cmd_q.dst_y)} + {1'b0, dl_data[2*COOR_WIDTH-1:COOR_WIDTH]};

    assign wr_en = dl_valid
                && (rom_data != TRANSPARENT_KEY)
                && !wx_full[COOR_WIDTH] && !wy_full[COOR_WIDTH]
                && (wx_full < (COOR_WIDTH+1)'(SCREEN_W))
                && (wy_full < (COOR_WIDTH+1)'(SCREEN_H));

    assign wr_x    = dl_valid ? wx_full[COOR_WIDTH-1:0] : '0;
    assign wr_y    = dl_valid ? wy_full[COOR_WIDTH-1:0] : '0;
    assign wr_data = dl_valid ? rom_data : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed, table-driven bench for sprite_blitter with a latency-2 sheet ROM model.
module tb_sprite_blitter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] src_x, src_y, dst_x, dst_y, width, height;
    logic        mirror_x;
    logic        busy, done, rom_en, wr_en;
    logic [18:0] rom_addr;
    logic [11:0] rom_data, wr_x, wr_y, wr_data;

    int checks = 0;
    int errors = 0;
    int key_addr = -1;

    always #5 clk = ~clk;

    sprite_blitter #(.ROM_LATENCY(L)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_x    (src_x),
        .src_y    (src_y),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .width    (width),
        .height   (height),
        .mirror_x (mirror_x),
        .busy     (busy),
        .done     (done),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data)
    );

    function automatic logic [11:0] rom_fn(input int addr);
        if (addr == key_addr) return 12'h000;
        return 12'((addr & 'hFFF) | 'h800);
    endfunction

    logic [11:0] rom_pipe [L];
    initial for (int i = 0; i < L; i++) rom_pipe[i] = '0;

    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(int'(rom_addr));
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[L-1];

    typedef struct {
        int src_x, src_y, dst_x, dst_y, w, h;
        int mirror;
        int key_addr;
        int restart_k;
        int exp_writes;
        int exp_done;
    } vec_t;

    vec_t vecs [10];

    function automatic int model_addr(input vec_t v, input int idx);
        int cx = idx % v.w;
        int cy = idx / v.w;
        int sx = (v.mirror != 0) ? (v.w - 1 - cx) : cx;
        return ((v.src_x + sx) + 404 * (v.src_y + cy)) & 'h7FFFF;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        src_x    = 12'(v.src_x);
        src_y    = 12'(v.src_y);
        dst_x    = 12'(v.dst_x);
        dst_y    = 12'(v.dst_y);
        width    = 12'(v.w);
        height   = 12'(v.h);
        mirror_x = (v.mirror != 0);
        start    = 1'b1;
    endtask

    task automatic scrambleInputs();
        src_x = 12'h555; src_y = 12'h0AA; dst_x = 12'h333;
        dst_y = 12'h111; width = 12'h007; height = 12'h005;
        mirror_x = ~mirror_x;
    endtask

    // Issues one command and checks every cycle against the raster-order model.
    task automatic runVector(input vec_t v, input string tag);
        int n = v.w * v.h;
        int writes = 0;
        int dones = 0;
        int done_cyc = -1;
        key_addr = v.key_addr;
        @(negedge clk);
        applyStimulus(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        scrambleInputs();
        for (int k = 1; k <= n + L + 3; k++) begin
            @(negedge clk);
            checkOutput({tag, " busy"}, int'(busy), int'(n > 0 && k <= n + L));
            checkOutput({tag, " rom_en"}, int'(rom_en), int'(n > 0 && k <= n));
            if (n > 0 && k <= n && rom_en)
                checkOutput({tag, " rom_addr"}, int'(rom_addr), model_addr(v, k - 1));
            if (n > 0 && k >= 1 + L && k <= n + L) begin
                int idx = k - 1 - L;
                int ex = v.dst_x + idx % v.w;
                int ey = v.dst_y + idx / v.w;
                int ed = int'(rom_fn(model_addr(v, idx)));
                int ee = int'(ed != 0 && ex < 640 && ey < 480);
                checkOutput({tag, " wr_en"}, int'(wr_en), ee);
                if (ee != 0 && wr_en) begin
                    checkOutput({tag, " wr_x"}, int'(wr_x), ex);
                    checkOutput({tag, " wr_y"}, int'(wr_y), ey);
                    checkOutput({tag, " wr_data"}, int'(wr_data), ed);
                end
            end else begin
                checkOutput({tag, " wr_en idle"}, int'(wr_en), 0);
            end
            checkOutput({tag, " done"}, int'(done), int'((n == 0) ? (k == 1) : (k == n + L + 1)));
            if (wr_en) writes++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k == v.restart_k) begin
                start  = 1'b1;
                width  = 12'd0;
                height = 12'd0;
                dst_x  = 12'd0;
            end else begin
                start = 1'b0;
            end
        end
        checkOutput({tag, " write count"}, writes, v.exp_writes);
        checkOutput({tag, " done cycle"}, done_cyc, v.exp_done);
        checkOutput({tag, " done count"}, dones, 1);
        key_addr = -1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
        checkOutput({tag, " rom_en"}, int'(rom_en), 0);
        checkOutput({tag, " rom_addr"}, int'(rom_addr), 0);
        checkOutput({tag, " wr_en"}, int'(wr_en), 0);
        checkOutput({tag, " wr_x"}, int'(wr_x), 0);
        checkOutput({tag, " wr_y"}, int'(wr_y), 0);
        checkOutput({tag, " wr_data"}, int'(wr_data), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t b2b_a, b2b_b;
        int cyc, seen, bad;

        rst_n = 1'b1;
        start = 1'b0;
        src_x = '0; src_y = '0; dst_x = '0; dst_y = '0;
        width = '0; height = '0; mirror_x = 1'b0;

        vecs[0] = '{0, 0, 10,   20,  3, 2,  0, -1, 0, 6,  9};
        vecs[1] = '{0, 0, 10,   20,  3, 2,  1, -1, 0, 6,  9};
        vecs[2] = '{0, 0, 10,   20,  3, 2,  0,  1, 0, 5,  9};
        vecs[3] = '{0, 0, 10,   20,  3, 2,  1,  1, 0, 5,  9};
        vecs[4] = '{0, 0, 638,  20,  4, 1,  0, -1, 0, 2,  7};
        vecs[5] = '{0, 0, 4094, 20,  4, 1,  0, -1, 0, 0,  7};
        vecs[6] = '{0, 0, 10,   20,  0, 3,  0, -1, 0, 0,  1};
        vecs[7] = '{5, 7, 100,  470, 2, 12, 0, -1, 0, 20, 27};
        vecs[8] = '{0, 0, 10,   20,  3, 2,  0, -1, 3, 6,  9};
        vecs[9] = '{0, 0, 10,   20,  5, 0,  0, -1, 0, 0,  1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b0;

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in cycle 3 of a 4x4 blit must abort it silently.
        @(negedge clk);
        applyStimulus('{0, 0, 50, 60, 4, 4, 0, -1, 0, 0, 0});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("abort");
        rst_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || wr_en || busy) bad++;
        end
        checkOutput("abort quiet", bad, 0);
        runVector(vecs[0], "after_abort");

        // A start in the done cycle is taken immediately.
        b2b_a = '{0, 0, 10, 20, 3, 2, 0, -1, 0, 6, 9};
        b2b_b = '{2, 1, 30, 40, 2, 2, 0, -1, 0, 4, 7};
        @(negedge clk);
        applyStimulus(b2b_a);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        seen = 0;
        while (cyc < 20 && seen == 0) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
        end
        checkOutput("b2b first done cycle", cyc, 9);
        applyStimulus(b2b_b);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("b2b rom_en", int'(rom_en), 1);
        checkOutput("b2b busy", int'(busy), 1);
        checkOutput("b2b rom_addr", int'(rom_addr), 406);
        cyc = 1;
        seen = 0;
        while (cyc < 20 && seen == 0) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
        end
        checkOutput("b2b second done cycle", cyc, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite blitter. It copies a width×height rectangle from a sprite-sheet ROM to the frame-buffer write port at a screen origin, with optional horizontal mirroring, colour-key transparency and screen-edge clipping. It sits between the scene sequencer, which issues one blit command per sprite, and the frame-buffer writer. It runs a start/busy/done handshake and drives an external synchronous ROM with configurable read latency.

## Interface
- COOR_WIDTH, 12, width of all coordinate and size fields
- ROM_ADDR_WIDTH, 19, sprite-sheet ROM address width
- SHEET_WIDTH, 404, sheet row pitch in pixels
- PIXEL_WIDTH, 12, pixel data width (RGB444)
- ROM_LATENCY, 2, cycles from rom_addr/rom_en to valid rom_data (≥1)
- SCREEN_W, 640, screen width; columns ≥ this are clipped
- SCREEN_H, 480, screen height; rows ≥ this are clipped
- TRANSPARENT_KEY, 12'h000, pixel value that is never written

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-high despite the name
- start  in  1  command strobe; sampled only when idle
- src_x, src_y  in  COOR_WIDTH  top-left of the sprite in the sheet
- dst_x, dst_y  in  COOR_WIDTH  top-left of the sprite on screen
- width, height  in  COOR_WIDTH  sprite size in pixels
- mirror_x  in  1  horizontal flip
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_ADDR_WIDTH  ROM read address
- rom_data  in  PIXEL_WIDTH  ROM read data, ROM_LATENCY cycles after the address
- wr_en, wr_x, wr_y, wr_data  out  1/COOR_WIDTH/COOR_WIDTH/PIXEL_WIDTH  frame-buffer write

## Operation
- FSM has three states: IDLE, SCAN, DRAIN.
- IDLE: busy=0. When start=1, all command inputs are latched. If width=0 or height=0, the FSM stays in IDLE and pulses done on the next cycle with no ROM access. Otherwise it goes to SCAN.
- SCAN: busy=1, rom_en=1. One read is issued per cycle.
  - Counters cx (0..w-1) and cy (0..h-1) advance raster order; cx wraps to 0 and cy increments.
  - sx = mirror ? w-1-cx : cx.
  - rom_addr = (src_x+sx) + SHEET_WIDTH*(src_y+cy). Computed at ROM_ADDR_WIDTH bits and truncated; no range check.
  - After the read at (w-1, h-1), the FSM goes to DRAIN.
- DRAIN: busy=1, rom_en=0. The FSM waits ROM_LATENCY cycles for the pipeline to empty, then goes to IDLE with done=1 in that cycle.
- start is ignored while busy. start in the same cycle as done is accepted.
- Delay line: ROM_LATENCY stages carry {valid, cx, cy}, aligned with rom_data.
- Write port, from the delay-line output:
  - wr_x = dst_x+cx and wr_y = dst_y+cy, each computed with one extra carry bit.
  - wr_data = rom_data.
  - wr_en = valid ∧ rom_data≠TRANSPARENT_KEY ∧ no carry ∧ wr_x<SCREEN_W ∧ wr_y<SCREEN_H.
- Mirroring changes the read order only. Write coordinates always go left-to-right.
- Reset value of every output is 0. Reset clears the FSM to IDLE, all delay-line valids and the counters.
- Reset mid-blit aborts the blit: no done, no further wr_en.

## Timing
- start sampled at edge 0 → first rom_addr in cycle 1 → first wr_en candidate in cycle 1+ROM_LATENCY.
- For N=w·h: last read in cycle N, last write in cycle N+ROM_LATENCY, done in cycle N+ROM_LATENCY+1.
- busy is high from cycle 1 through cycle N+ROM_LATENCY. It is low in the done cycle.
- Zero-size command: done in cycle 1, busy never rises.
- Back-to-back: a start in the done cycle gives its first rom_addr in the next cycle.

## Structure
- Package sprite_pkg holds:
  - the blit_state_t enum (IDLE, SCAN, DRAIN);
  - the blit_cmd_t struct (src, dst, size, mirror);
  - the default SCREEN_W/SCREEN_H/TRANSPARENT_KEY constants.
- Sub-module blit_delay_line, parametrised by depth and payload width, with synchronous clear. It carries valid plus coordinates.

## Test plan
- Setup for all scenarios: ROM model with L=2, returning (addr & 12'hFFF)|12'h800.
- 3×2 blit, src(0,0), dst(10,20) → 6 writes with addresses 0,1,2,404,405,406, at (10..12, 20) then (10..12, 21). done in cycle 9. busy high for cycles 1–8.
- Same command with mirror_x=1 → data from addresses 2,1,0,406,405,404 written at x=10,11,12. Timing identical.
- ROM entry at address 1 set to 12'h000 → wr_en low for that slot only. The other 5 writes and done in cycle 9 are unchanged.
- dst_x=638, width=4, height=1 → wr_en only at x=638 and 639. dst_x=4094 wraps → no writes. done still in cycle 4+2+1=7.
- width=0 → done in cycle 1, rom_en never asserted. start asserted while busy → ignored, with no extra writes or done.
- Reset asserted in cycle 3 of a 4×4 blit → all outputs 0 the next cycle, no done. A new start after reset runs a full blit.
